// File: rtl/matmul_stream_ctrl.sv
// matmul_stream_ctrl
//   Streaming wrapper around the N x N systolic matmul array controller.
//   It collects 2*N*N operand elements from a valid/ready input stream into
//   flat A/B vectors, enables the array until it reports done (or a timeout
//   expires), and then replays the captured N*N result as a valid/ready
//   output stream.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_s_valid/o_s_ready/i_s_data   input element stream (A then B, row-major)
//   i_mode                    job mode, latched with element 0
//   o_A, o_B, o_en, o_mode    operands, enable and mode to the array
//   i_C, i_done               flat result and done flag from the array
//   o_m_valid/i_m_ready/o_m_data/o_m_last  result element stream
//   o_busy                    high while running or draining
//   o_err                     sticky timeout flag, cleared only by reset
module matmul_stream_ctrl #(
    parameter int W       = 16,
    parameter int N       = 3,
    parameter int TIMEOUT = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [W-1:0]     i_s_data,
    input  logic             i_mode,
    output logic [W*N*N-1:0] o_A,
    output logic [W*N*N-1:0] o_B,
    output logic             o_en,
    output logic             o_mode,
    input  logic [W*N*N-1:0] i_C,
    input  logic             i_done,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [W-1:0]     o_m_data,
    output logic             o_m_last,
    output logic             o_busy,
    output logic             o_err
);

    localparam int NN = N * N;
    localparam int KW = $clog2(2 * NN);
    localparam int JW = (NN > 1) ? $clog2(NN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [JW-1:0]   j_q, j_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [W*NN-1:0] a_q, a_d;
    logic [W*NN-1:0] b_q, b_d;
    logic [W*NN-1:0] c_q, c_d;
    logic            mode_q, mode_d;
    logic            err_q, err_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        tmo_d   = tmo_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        mode_d  = mode_q;
        err_d   = err_q;

        case (state_q)
            S_LOAD: begin
                if (i_s_valid) begin
                    if (k_q == '0) begin
                        mode_d = i_mode;
                    end
                    // First N*N elements are A, the next N*N are B.
                    if (int'(k_q) < NN) begin
                        a_d[int'(k_q)*W +: W] = i_s_data;
                    end else begin
                        b_d[(int'(k_q) - NN)*W +: W] = i_s_data;
                    end
                    if (int'(k_q) == 2*NN - 1) begin
                        k_d     = '0;
                        tmo_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_RUN: begin
                // Done has priority over a timeout expiring in the same cycle.
                if (i_done) begin
                    c_d     = i_C;
                    state_d = S_DRAIN;
                end else if (int'(tmo_q) == TIMEOUT - 1) begin
                    c_d     = '0;
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DRAIN: begin
                if (i_m_ready) begin
                    if (int'(j_q) == NN - 1) begin
                        j_d     = '0;
                        state_d = S_LOAD;
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_LOAD;
            k_q     <= '0;
            j_q     <= '0;
            tmo_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            tmo_q   <= tmo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    // All stream outputs are decoded from registered state only.
    assign o_s_ready = (state_q == S_LOAD);
    assign o_en      = (state_q == S_RUN);
    assign o_m_valid = (state_q == S_DRAIN);
    assign o_m_last  = (state_q == S_DRAIN) && (int'(j_q) == NN - 1);
    assign o_m_data  = c_q[int'(j_q)*W +: W];
    assign o_busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign o_A       = a_q;
    assign o_B       = b_q;
    assign o_mode    = mode_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
module tb_matmul_stream_ctrl;

    localparam int W  = 16;
    localparam int N  = 3;
    localparam int NN = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [W-1:0]      s_data = '0;
    logic              mode_in = 1'b0;
    logic [W*NN-1:0]   o_a, o_b;
    logic              en, mode_out;
    logic [W*NN-1:0]   c_in;
    logic              done;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [W-1:0]      m_data;
    logic              m_last, busy, err;

    int checks   = 0;
    int failures = 0;

    // Stub array: 0 = done 9 cycles after o_en rises, 2 = never done.
    int                stub_mode = 0;
    logic [W*NN-1:0]   stub_c = '0;
    int                stub_cnt = 0;

    logic [W-1:0] va [NN];
    logic [W-1:0] vb [NN];
    logic [W-1:0] vexp [NN];

    always #5 clk = ~clk;

    matmul_stream_ctrl #(.W(W), .N(N), .TIMEOUT(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data), .i_mode(mode_in),
        .o_A(o_a), .o_B(o_b), .o_en(en), .o_mode(mode_out),
        .i_C(c_in), .i_done(done),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data), .o_m_last(m_last),
        .o_busy(busy), .o_err(err)
    );

    assign c_in = stub_c;

    always @(posedge clk) begin
        if (!en) begin
            stub_cnt <= 0;
            done     <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            done     <= (stub_mode == 0) && (stub_cnt == 8);
        end
    end

    task automatic chk(input string name, input logic [W*NN-1:0] act, input logic [W*NN-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    task automatic load_job(input logic mode, input bit bubbles);
        logic [W*NN-1:0] pa, pb;
        pa = '0;
        pb = '0;
        for (int i = 0; i < 2*NN; i++) begin
            if (bubbles) begin
                s_valid = 1'b0;
                s_data  = 16'hDEAD;
                @(negedge clk);
            end
            checks++;
            if (s_ready !== 1'b1 || en !== 1'b0) begin
                failures++;
                $display("FAIL load_ready idx=%0d actual ready=%b en=%b required ready=1 en=0", i, s_ready, en);
            end
            s_valid = 1'b1;
            s_data  = (i < NN) ? va[i] : vb[i-NN];
            mode_in = (i == 0) ? mode : ~mode;
            if (i < NN) pa[i*W +: W] = va[i]; else pb[(i-NN)*W +: W] = vb[i-NN];
            @(negedge clk);
        end
        s_valid = 1'b0;
        mode_in = ~mode;
        chk("run_entry_en", {143'd0, en}, {143'd0, 1'b1});
        chk("run_entry_ready", {143'd0, s_ready}, '0);
        chk("packed_A", o_a, pa);
        chk("packed_B", o_b, pb);
        chk("mode_latched", {143'd0, mode_out}, {143'd0, mode});
    endtask

    task automatic wait_run(input int exp_cycles);
        int n;
        n = 0;
        while (en === 1'b1 && n < 200) begin
            if (busy !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL busy_in_run actual=%b required=1", busy);
            end
            n++;
            @(negedge clk);
        end
        chk("en_cycles", n, exp_cycles);
        chk("valid_after_run", {143'd0, m_valid}, {143'd0, 1'b1});
    endtask

    task automatic drain(input bit backpressure);
        int hs, p;
        bit stalled;
        logic [W-1:0] prev;
        hs = 0;
        p = 0;
        stalled = 0;
        prev = '0;
        while (hs < NN && p < 100) begin
            if (m_valid !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL drain_valid cyc=%0d actual=%b required=1", p, m_valid);
            end
            if (stalled) chk("stall_stable", m_data, prev);
            m_ready = backpressure ? ((p % 4) == 0 || (p % 4) == 3) : 1'b1;
            if (m_ready) begin
                chk("out_data", m_data, vexp[hs]);
                chk("out_last", {143'd0, m_last}, {143'd0, (hs == NN-1)});
                hs++;
            end
            stalled = !m_ready;
            prev = m_data;
            p++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        chk("handshakes", hs, NN);
        chk("back_to_load_ready", {143'd0, s_ready}, {143'd0, 1'b1});
        chk("back_to_load_valid", {143'd0, m_valid}, '0);
        chk("back_to_load_busy", {143'd0, busy}, '0);
    endtask

    task automatic set_stub_100;
        for (int k = 0; k < NN; k++) begin
            stub_c[k*W +: W] = W'(100 + k);
            vexp[k] = W'(100 + k);
            va[k] = W'(16'h0A00 + k);
            vb[k] = W'(16'h0B00 + k);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {143'd0, s_ready}, {143'd0, 1'b1});
        chk("rst_en", {143'd0, en}, '0);
        chk("rst_mvalid", {143'd0, m_valid}, '0);
        chk("rst_mlast", {143'd0, m_last}, '0);
        chk("rst_busy", {143'd0, busy}, '0);
        chk("rst_err", {143'd0, err}, '0);
        chk("rst_mode", {143'd0, mode_out}, '0);
        chk("rst_A", o_a, '0);
        chk("rst_B", o_b, '0);
        chk("rst_mdata", m_data, '0);
    endtask

    task automatic test_integration;
        // A = identity, B = 1..9, so A*B = 1..9.
        for (int k = 0; k < NN; k++) begin
            va[k] = (k % 4 == 0) ? 16'd1 : 16'd0;
            vb[k] = W'(k + 1);
            vexp[k] = W'(k + 1);
        end
        stub_mode = 0;
        stub_c = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                for (int t = 0; t < N; t++)
                    stub_c[(r*N+c)*W +: W] = stub_c[(r*N+c)*W +: W] + va[r*N+t] * vb[t*N+c];
        load_job(1'b0, 0);
        wait_run(10);
        drain(0);
    endtask

    task automatic test_stub_mode;
        set_stub_100();
        stub_mode = 0;
        load_job(1'b1, 0);
        wait_run(10);
        drain(0);
        chk("mode_held_after_drain", {143'd0, mode_out}, {143'd0, 1'b1});
    endtask

    task automatic test_backpressure;
        set_stub_100();
        load_job(1'b0, 0);
        wait_run(10);
        drain(1);
    endtask

    task automatic test_bubbles;
        set_stub_100();
        load_job(1'b1, 1);
        wait_run(10);
        drain(0);
    endtask

    task automatic test_reset_in_run;
        set_stub_100();
        stub_mode = 2;
        load_job(1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_run_en", {143'd0, en}, {143'd0, 1'b1});
        test_reset();
        stub_mode = 0;
        load_job(1'b1, 0);
        wait_run(10);
        drain(0);
    endtask

    task automatic test_timeout;
        set_stub_100();
        stub_mode = 2;
        for (int k = 0; k < NN; k++) vexp[k] = '0;
        load_job(1'b0, 0);
        chk("err_before_timeout", {143'd0, err}, '0);
        wait_run(32);
        chk("err_after_timeout", {143'd0, err}, {143'd0, 1'b1});
        drain(0);
        // Next job completes normally but the error flag stays set.
        stub_mode = 0;
        set_stub_100();
        load_job(1'b1, 0);
        wait_run(10);
        drain(0);
        chk("err_sticky", {143'd0, err}, {143'd0, 1'b1});
        test_reset();
    endtask

    initial begin
        test_reset();
        test_integration();
        test_stub_mode();
        test_backpressure();
        test_bubbles();
        test_reset_in_run();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
